range_finder_pio_in_echo: RTL

- Avalon-MM slave input PIO for the range finder's single-bit echo line. It is the read-direction counterpart of the output PIO that drives the trigger/watchdog bit.
- Synchronizes the external input and captures edges into a sticky register.
- Raises a maskable interrupt on a captured edge.
- Measures the high-pulse width of the echo in clk cycles so software can compute distance.

---
 rtl/range_finder_pio_in_echo.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/range_finder_pio_in_echo.sv
`timescale 1ns/1ps
// Avalon-MM input PIO for the range finder echo line: synchronizer, sticky edge capture, maskable irq, pulse-width meter.
// Read latency 1 cycle (readdata registered every cycle); writes take effect on the next clk edge.
// No backpressure: slave never stalls, irq is combinational from the edgecapture/irqmask registers.
module range_finder_pio_in_echo #(
  parameter int EDGE_TYPE   = 1,   // 0 = rising, 1 = falling, 2 = any
  parameter int CNT_W       = 24,  // pulse-width counter width (1..32)
  parameter int SYNC_STAGES = 2    // input synchronizer depth (2..4)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  typedef enum logic {IDLE, MEASURE} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic                   edge_hit;
  logic                   irqmask;
  logic                   edgecapture;
  logic [CNT_W-1:0]       counter;
  logic [CNT_W-1:0]       width;
  logic                   busy;
  state_t                 state;
  logic                   wr_en;
  logic [31:0]            rd_mux;
  logic                   unused_writedata;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Select which synchronized edge is sticky in edgecapture.
  always_comb begin
    edge_hit = 1'b0;
    case (EDGE_TYPE)
      0:       edge_hit = rise;
      1:       edge_hit = fall;
      default: edge_hit = rise | fall;
    endcase
  end

  assign wr_en            = chipselect & ~write_n;
  assign irq              = edgecapture & irqmask;
  // Only bit 0 of the write bus is meaningful in this register map.
  assign unused_writedata = ^writedata[31:1];

  // Synchronize the asynchronous echo input and keep one cycle of history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      s_d    <= s;
    end
  end

  // Interrupt mask register (address 1).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= 1'b0;
    end else if (wr_en && address == 2'd1) begin
      irqmask <= writedata[0];
    end
  end

  // Sticky edge capture, write-one-to-clear; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= 1'b0;
    end else if (edge_hit) begin
      edgecapture <= 1'b1;
    end else if (wr_en && address == 2'd2 && writedata[0]) begin
      edgecapture <= 1'b0;
    end
  end

  // Pulse-width meter: count cycles with s high, saturating, and publish on the falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      counter <= '0;
      width   <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            counter <= {{(CNT_W-1){1'b0}}, 1'b1};
            busy    <= 1'b1;
            state   <= MEASURE;
          end
        end
        MEASURE: begin
          if (fall) begin
            width <= counter;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (s && counter != {CNT_W{1'b1}}) begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address decode for reads; busy owns bit 31 even when the counter is 32 bits wide.
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: rd_mux[0] = s;
      2'd1: rd_mux[0] = irqmask;
      2'd2: rd_mux[0] = edgecapture;
      default: begin
        rd_mux[CNT_W-1:0] = width;
        rd_mux[31]        = busy;
      end
    endcase
  end

  // Register read data every cycle for a fixed one-cycle read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule
